window_3x3_generator: RTL and testbench
=======================================

WINDOW_3X3_GENERATOR -- requirements
Module: window_3x3_generator

Interface
REQ-001 Parameter IMG_WIDTH, default 640, pixels per line (SHALL be >= 3).
REQ-002 Parameter IMG_HEIGHT, default 480, lines per frame (SHALL be >= 3).
REQ-003 clk  input  1  clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 input_is_valid  input  1  qualifies input_pixel; one pixel accepted per cycle when high.
REQ-006 input_pixel  input  24  raster-order RGB pixel, R=[23:16], G=[15:8], B=[7:0].
REQ-007 input_pixel_1..input_pixel_9  output  24 each  3x3 window, row-major, _1 = top-left (oldest line, oldest column), _9 = bottom-right (newest accepted pixel).
REQ-008 output_is_valid  output  1  window outputs hold a complete in-frame 3x3 window.
REQ-009 frame_done  output  1  single-cycle pulse marking acceptance of a frame's last pixel.

Function
REQ-010 Block SHALL keep column counter (0..IMG_WIDTH-1) and row counter (0..IMG_HEIGHT-1) of the next pixel to accept.
REQ-011 On each accepted pixel, column SHALL increment; at IMG_WIDTH-1 it SHALL wrap to 0 and row SHALL increment; at last pixel of frame both SHALL wrap to 0.
REQ-012 Two line buffers of IMG_WIDTH x 24 bits SHALL hold the previous two lines; on accept, the value at current column moves from line buffer 1 to line buffer 2 and input_pixel is written to line buffer 1.
REQ-013 A 3x3 register window SHALL shift one column left per accepted pixel, new right column = {line buffer 2, line buffer 1, input_pixel} at current column.
REQ-014 When input_is_valid is low, counters, line buffers, window and outputs SHALL hold; output_is_valid SHALL be 0 that cycle.
REQ-015 Latency: window outputs and output_is_valid SHALL be registered, appearing exactly 1 cycle after the accepted pixel that completes the window.
REQ-016 output_is_valid SHALL be 1 only for accepted pixels with row >= 2 and column >= 2; exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) valid windows per frame.
REQ-017 Windows SHALL never span a line wrap (columns 0 and 1 produce no valid output); no edge padding.
REQ-018 frame_done SHALL assert 1 cycle after acceptance of pixel (IMG_HEIGHT-1, IMG_WIDTH-1), coincident with that frame's last output_is_valid.
REQ-019 Back-to-back frames SHALL stream without gap; stale line-buffer data from previous frame SHALL never appear in a valid window.
REQ-020 Throughput: one pixel per cycle sustained, no backpressure.

Reset
REQ-021 On rst, counters SHALL go to 0, output_is_valid and frame_done to 0, all window outputs to 24'd0.
REQ-022 Line buffer contents need not be cleared; REQ-016 gating guarantees they are unused until rewritten.
REQ-023 rst mid-frame SHALL abandon the frame; next accepted pixel is (row 0, col 0).

Structure
REQ-024 Pixel width (24), channel width (8) and default IMG_WIDTH/IMG_HEIGHT SHALL live in shared package dehaze_pkg.
REQ-025 One sub-module window_line_buffer (single-port read-before-write, IMG_WIDTH x 24, instantiated twice, inferred as block RAM or distributed RAM) is natural.
REQ-026 Outputs SHALL connect directly to the atmospheric light estimation stage's 3x3 window and valid inputs.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = raster index)
REQ-027 Continuous 16 pixels -> first output_is_valid 1 cycle after index 10; window = 0,1,2,4,5,6,8,9,10.
REQ-028 Same frame -> exactly 4 valid windows, last = 5,6,7,9,10,11,13,14,15, with frame_done high same cycle.
REQ-029 input_is_valid toggled 1/0 every cycle -> identical window sequence, output_is_valid never high in idle-following cycles.
REQ-030 Two frames back-to-back (second frame values +100) -> second frame's first window = 100,101,102,104,105,106,108,109,110; no mixed-frame windows.
REQ-031 rst asserted after index 6, then fresh frame -> no valid until new index 10; outputs 0 during/after reset until first valid.

Source files
------------

// File: rtl/dehaze_pkg.sv
// Shared constants for the dehaze pipeline: pixel/channel widths and the
// default frame geometry used by the windowing and estimation stages.
package dehaze_pkg;

    localparam int PIXEL_W            = 24;
    localparam int CHAN_W             = 8;
    localparam int DEFAULT_IMG_WIDTH  = 640;
    localparam int DEFAULT_IMG_HEIGHT = 480;

    typedef logic [PIXEL_W-1:0] pixel_t;

endpackage

// File: rtl/window_line_buffer.sv
// One line of pixel storage: asynchronous read of the addressed entry and a
// write on the same clock edge, so the old contents are seen before overwrite.
module window_line_buffer
    import dehaze_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_IMG_WIDTH,
    parameter int DATA_W = PIXEL_W,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Line storage write port; contents are never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/window_3x3_generator.sv
// Streams raster pixels into two line buffers and a 3x3 shift window, and
// presents each complete in-frame window one cycle after its last pixel.
module window_3x3_generator
    import dehaze_pkg::*;
#(
    parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                input_is_valid,
    input  logic [PIXEL_W-1:0]  input_pixel,
    output logic [PIXEL_W-1:0]  input_pixel_1,
    output logic [PIXEL_W-1:0]  input_pixel_2,
    output logic [PIXEL_W-1:0]  input_pixel_3,
    output logic [PIXEL_W-1:0]  input_pixel_4,
    output logic [PIXEL_W-1:0]  input_pixel_5,
    output logic [PIXEL_W-1:0]  input_pixel_6,
    output logic [PIXEL_W-1:0]  input_pixel_7,
    output logic [PIXEL_W-1:0]  input_pixel_8,
    output logic [PIXEL_W-1:0]  input_pixel_9,
    output logic                output_is_valid,
    output logic                frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(2);
    localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(2);

    logic [CW-1:0]      col_q, col_d;
    logic [RW-1:0]      row_q, row_d;
    logic [PIXEL_W-1:0] win_q [9];
    logic [PIXEL_W-1:0] win_d [9];
    logic [PIXEL_W-1:0] out_q [9];
    logic [PIXEL_W-1:0] out_d [9];
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic [PIXEL_W-1:0] lb1_rd_s, lb2_rd_s;
    logic [PIXEL_W-1:0] new_col_s [3];

    window_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (PIXEL_W),
        .ADDR_W (CW)
    ) u_line_buf_1 (
        .clk   (clk),
        .we    (input_is_valid),
        .addr  (col_q),
        .wdata (input_pixel),
        .rdata (lb1_rd_s)
    );

    window_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (PIXEL_W),
        .ADDR_W (CW)
    ) u_line_buf_2 (
        .clk   (clk),
        .we    (input_is_valid),
        .addr  (col_q),
        .wdata (lb1_rd_s),
        .rdata (lb2_rd_s)
    );

    assign new_col_s[0] = lb2_rd_s;
    assign new_col_s[1] = lb1_rd_s;
    assign new_col_s[2] = input_pixel;

    // Raster position of the next pixel to accept.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (input_is_valid) begin
            if (col_q == COL_LAST) begin
                col_d = {CW{1'b0}};
                if (row_q == ROW_LAST) begin
                    row_d = {RW{1'b0}};
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
                row_d = row_q;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Window shift, and the output window that only moves on complete windows
    // so stale or partial data never reaches the next stage.
    always_comb begin
        valid_d = input_is_valid && (row_q >= ROW_FIRST_WIN) && (col_q >= COL_FIRST_WIN);
        done_d  = input_is_valid && (row_q == ROW_LAST) && (col_q == COL_LAST);
        for (int r = 0; r < 3; r++) begin
            if (input_is_valid) begin
                win_d[3*r]     = win_q[3*r + 1];
                win_d[3*r + 1] = win_q[3*r + 2];
                win_d[3*r + 2] = new_col_s[r];
            end else begin
                win_d[3*r]     = win_q[3*r];
                win_d[3*r + 1] = win_q[3*r + 1];
                win_d[3*r + 2] = win_q[3*r + 2];
            end
        end
        for (int k = 0; k < 9; k++) begin
            if (valid_d) begin
                out_d[k] = win_d[k];
            end else begin
                out_d[k] = out_q[k];
            end
        end
    end

    // State registers with synchronous reset; line buffers are left as-is.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= {CW{1'b0}};
            row_q   <= {RW{1'b0}};
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= {PIXEL_W{1'b0}};
                out_q[k] <= {PIXEL_W{1'b0}};
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            for (int k = 0; k < 9; k++) begin
                win_q[k] <= win_d[k];
                out_q[k] <= out_d[k];
            end
        end
    end

    assign input_pixel_1   = out_q[0];
    assign input_pixel_2   = out_q[1];
    assign input_pixel_3   = out_q[2];
    assign input_pixel_4   = out_q[3];
    assign input_pixel_5   = out_q[4];
    assign input_pixel_6   = out_q[5];
    assign input_pixel_7   = out_q[6];
    assign input_pixel_8   = out_q[7];
    assign input_pixel_9   = out_q[8];
    assign output_is_valid = valid_q;
    assign frame_done      = done_q;

endmodule

// File: tb/tb_window_3x3_generator.sv
// Directed bench for window_3x3_generator on a 4x4 frame whose pixel values
// are the raster index plus a per-frame base.
module tb_window_3x3_generator;

    localparam int W = 4;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        input_is_valid;
    logic [23:0] input_pixel;
    logic [23:0] p1, p2, p3, p4, p5, p6, p7, p8, p9;
    logic        ov, fd;

    int total = 0;
    int bad   = 0;
    logic [215:0] hold_win;

    always #5 clk = ~clk;

    window_3x3_generator #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .input_is_valid  (input_is_valid),
        .input_pixel     (input_pixel),
        .input_pixel_1   (p1),
        .input_pixel_2   (p2),
        .input_pixel_3   (p3),
        .input_pixel_4   (p4),
        .input_pixel_5   (p5),
        .input_pixel_6   (p6),
        .input_pixel_7   (p7),
        .input_pixel_8   (p8),
        .input_pixel_9   (p9),
        .output_is_valid (ov),
        .frame_done      (fd)
    );

    function automatic logic [215:0] obs_win();
        return {p1, p2, p3, p4, p5, p6, p7, p8, p9};
    endfunction

    function automatic logic [215:0] pack9(int a, int b, int c, int d, int e,
                                           int f, int g, int h, int i);
        return {24'(a), 24'(b), 24'(c), 24'(d), 24'(e), 24'(f), 24'(g), 24'(h), 24'(i)};
    endfunction

    // Window whose bottom-right pixel sits at (r, c) of a frame starting at base.
    function automatic logic [215:0] win_at(int base, int r, int c);
        logic [215:0] v;
        v = 216'd0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                v = {v[191:0], 24'(base + (r - 2 + i) * W + (c - 2 + j))};
            end
        end
        return v;
    endfunction

    task automatic chk(string tag, logic [215:0] obs, logic [215:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(logic v, logic [23:0] pix);
        input_is_valid = v;
        input_pixel    = pix;
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(int base, bit toggle);
        int nvalid;
        nvalid = 0;
        for (int idx = 0; idx < W * H; idx++) begin
            int  r;
            int  c;
            bit  ev;
            bit  ef;
            r  = idx / W;
            c  = idx % W;
            ev = (r >= 2) && (c >= 2);
            ef = (idx == W * H - 1);
            if (toggle) begin
                step(1'b0, 24'hABCDEF);
                chk("idle_valid", 216'(ov), 216'd0);
                chk("idle_done", 216'(fd), 216'd0);
                chk("idle_hold", obs_win(), hold_win);
            end
            step(1'b1, 24'(base + idx));
            chk("valid", 216'(ov), 216'(ev));
            chk("frame_done", 216'(fd), 216'(ef));
            if (ev) begin
                hold_win = win_at(base, r, c);
                nvalid++;
            end
            chk("window", obs_win(), hold_win);
            if (idx == 10) begin
                chk("first_win", obs_win(), pack9(base, base + 1, base + 2, base + 4, base + 5,
                                                  base + 6, base + 8, base + 9, base + 10));
            end
            if (idx == 15) begin
                chk("last_win", obs_win(), pack9(base + 5, base + 6, base + 7, base + 9, base + 10,
                                                 base + 11, base + 13, base + 14, base + 15));
                chk("last_done", 216'(fd), 216'd1);
            end
        end
        chk("valid_count", 216'(nvalid), 216'd4);
    endtask

    initial begin
        rst            = 1'b1;
        input_is_valid = 1'b0;
        input_pixel    = 24'd0;
        hold_win       = 216'd0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("reset_valid", 216'(ov), 216'd0);
        chk("reset_done", 216'(fd), 216'd0);
        chk("reset_window", obs_win(), 216'd0);
        rst = 1'b0;

        // Two frames back to back, then a frame with idle cycles interleaved.
        run_frame(0, 1'b0);
        run_frame(100, 1'b0);
        run_frame(200, 1'b1);

        // Abandon a frame after index 6; reset wins over a valid input.
        for (int idx = 0; idx <= 6; idx++) begin
            step(1'b1, 24'(300 + idx));
        end
        chk("pre_reset_window", obs_win(), hold_win);
        rst = 1'b1;
        step(1'b1, 24'd999);
        step(1'b1, 24'd998);
        chk("mid_reset_valid", 216'(ov), 216'd0);
        chk("mid_reset_done", 216'(fd), 216'd0);
        chk("mid_reset_window", obs_win(), 216'd0);
        rst      = 1'b0;
        hold_win = 216'd0;
        run_frame(400, 1'b0);

        input_is_valid = 1'b0;
        step(1'b0, 24'd0);
        chk("tail_valid", 216'(ov), 216'd0);
        chk("tail_done", 216'(fd), 216'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
